// File: rtl/muldiv_pkg.sv
// Shared encodings, sequencer states and arithmetic helpers for the EX-stage
// multiply/divide unit.
package muldiv_pkg;

   localparam int WIDTH     = 32;
   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      MULDIV_OP_MULT  = 2'd0,
      MULDIV_OP_MULTU = 2'd1,
      MULDIV_OP_DIV   = 2'd2,
      MULDIV_OP_DIVU  = 2'd3
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } muldiv_state_e;

   // Extending both operands to 2*WIDTH makes the low half of an unsigned
   // multiply equal to the signed or unsigned full product.
   function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             is_signed);
      logic [2*WIDTH-1:0] ax;
      logic [2*WIDTH-1:0] bx;
      ax = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
      bx = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
      return ax * bx;
   endfunction

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             is_signed);
      return (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference when it does not go negative.
module div_radix2_step
   import muldiv_pkg::*;
(
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The partial remainder is always below the divisor, so one extra bit is
   // enough for both the shifted value and the borrow of the trial subtract.
   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {1'b0, divisor_i};
   assign q_o     = ~diff[WIDTH];
   assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: single-cycle registered multiply or 32-step
// restoring divide, stalling EX until HI/LO is written.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             done_o,
   output logic             hilo_we_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   muldiv_state_e    state, state_nxt;
   muldiv_op_e       op;
   logic [4:0]       count;
   logic [WIDTH-1:0] rem, dvd, divisor, a_lat;
   logic             q_neg, r_neg, div_zero;
   logic             accept, is_mul, is_signed, last_iter;
   logic [WIDTH-1:0] rem_step, quo_final;
   logic             q_bit;

   assign op        = muldiv_op_e'(op_i);
   assign is_mul    = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU);
   assign is_signed = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
   assign accept    = (state == IDLE) && start_i && !flush_i;
   assign last_iter = (state == DIV) && (count == 5'(DIV_ITERS - 1));

   // dvd shifts the dividend out MSB-first while quotient bits shift in at
   // the bottom; after the last step it holds the quotient magnitude.
   div_radix2_step u_step (
      .rem_i     (rem),
      .bit_i     (dvd[WIDTH-1]),
      .divisor_i (divisor),
      .rem_o     (rem_step),
      .q_o       (q_bit)
   );

   assign quo_final = {dvd[WIDTH-2:0], q_bit};

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      stall_o   = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               stall_o   = 1'b1;
               state_nxt = is_mul ? DONE : DIV;
            end
         end
         DIV: begin
            stall_o = 1'b1;
            if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            done_o    = !flush_i;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush_i) state_nxt = IDLE;
   end

   assign hilo_we_o = done_o;

   // NOTE: registers are updated with non-blocking assignments so every
   // flop samples the pre-edge value of its inputs, independent of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the whole datapath is reset, not just HI/LO, so a reset in the
   // middle of a divide leaves no stale operand or sign state behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         rem      <= '0;
         dvd      <= '0;
         divisor  <= '0;
         a_lat    <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         div_zero <= 1'b0;
         hi_o     <= '0;
         lo_o     <= '0;
      end else if (accept) begin
         if (is_mul) begin
            {hi_o, lo_o} <= mul_full(a_i, b_i, is_signed);
         end else begin
            dvd      <= magnitude(a_i, is_signed);
            divisor  <= magnitude(b_i, is_signed);
            a_lat    <= a_i;
            q_neg    <= is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_neg    <= is_signed && a_i[WIDTH-1];
            div_zero <= (b_i == '0);
            count    <= '0;
            rem      <= '0;
         end
      end else if ((state == DIV) && !flush_i) begin
         rem   <= rem_step;
         dvd   <= quo_final;
         count <= count + 5'd1;
         if (last_iter) begin
            if (div_zero) begin
               hi_o <= a_lat;
               lo_o <= '1;
            end else begin
               hi_o <= r_neg ? -rem_step : rem_step;
               lo_o <= q_neg ? -quo_final : quo_final;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a cycle-level arithmetic model checked
// every cycle, plus directed operations with hand-computed results.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'd0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        flush_i = 1'b0;
   logic        stall_o, done_o, hilo_we_o;
   logic [31:0] hi_o, lo_o;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .op_i      (op_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .flush_i   (flush_i),
      .stall_o   (stall_o),
      .done_o    (done_o),
      .hilo_we_o (hilo_we_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Architectural result {HI, LO} straight from the instruction definitions.
   function automatic logic [63:0] model_result(input logic [1:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MULDIV_OP_MULT:  return 64'(sa * sb);
         MULDIV_OP_MULTU: return {32'b0, a} * {32'b0, b};
         MULDIV_OP_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = 64'(sa / sb);
            r = 64'(sa % sb);
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Model: cycles left before completion, a one-cycle done flag and HI/LO.
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_pend = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            if (flush_i) m_left <= 0;
            else if (m_left == 1) begin
               m_left         <= 0;
               m_done         <= 1'b1;
               {m_hi, m_lo}   <= m_pend;
            end else m_left <= m_left - 1;
         end else if (!m_done && start_i && !flush_i) begin
            if (op_i == MULDIV_OP_MULT || op_i == MULDIV_OP_MULTU) begin
               m_done       <= 1'b1;
               {m_hi, m_lo} <= model_result(op_i, a_i, b_i);
            end else begin
               m_left <= 32;
               m_pend <= model_result(op_i, a_i, b_i);
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_stall", stall_o, (m_left > 0) || (m_left == 0 && !m_done && start_i && !flush_i));
      check("cyc_done", done_o, m_done && !flush_i);
      check("cyc_we", hilo_we_o, m_done && !flush_i);
      check("cyc_hi", hi_o, m_hi);
      check("cyc_lo", lo_o, m_lo);
   end

   // Leaves start_i high so a following call starts back-to-back from IDLE.
   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_e, input logic [31:0] lo_e,
                         input int lat_e, input bit scramble);
      int stalls = 0;
      int cyc = 0;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(negedge clk);
      while (!done_o && cyc < 100) begin
         if (stall_o) stalls++;
         cyc++;
         @(posedge clk); #1;
         if (scramble) begin
            a_i  = $urandom;
            b_i  = $urandom;
            op_i = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
      end
      check({name, "_done"}, done_o, 1'b1);
      check({name, "_we"}, hilo_we_o, 1'b1);
      check({name, "_latency"}, 64'(cyc), 64'(lat_e));
      check({name, "_stalls"}, 64'(stalls), 64'(lat_e));
      check({name, "_hi"}, hi_o, hi_e);
      check({name, "_lo"}, lo_o, lo_e);
      check({name, "_model"}, {m_hi, m_lo}, {hi_e, lo_e});
      if (scramble) begin
         op_i = op; a_i = a; b_i = b;
      end
   endtask

   initial begin
      int dones;
      #2;
      @(negedge clk);
      check("reset_hi", hi_o, 32'h0);
      check("reset_lo", lo_o, 32'h0);
      check("reset_done", done_o, 1'b0);
      check("reset_stall", stall_o, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op("multu_max_x2", MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1, 0);
      run_op("mult_m3_x5", MULDIV_OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1, 0);
      run_op("div_m7_2", MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1);
      run_op("divu_100_7", MULDIV_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
      run_op("divu_5_0", MULDIV_OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33, 0);
      run_op("div_m5_0", MULDIV_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, 0);
      run_op("div_ovf", MULDIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 0);
      run_op("div_7_m2", MULDIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, 0);
      run_op("divu_max_16", MULDIV_OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'hF, 32'h0FFF_FFFF, 33, 0);
      run_op("multu_max_max", MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1, 0);
      run_op("mult_min_min", MULDIV_OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1, 0);

      // Flush a divide in its tenth cycle after acceptance.
      @(posedge clk); #1;
      start_i = 1'b1; op_i = MULDIV_OP_DIV; a_i = 32'd1000; b_i = 32'd3;
      repeat (10) @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      check("flush_stall", stall_o, 1'b0);
      check("flush_done", done_o, 1'b0);
      check("flush_hi", hi_o, 32'h4000_0000);
      check("flush_lo", lo_o, 32'h0);
      run_op("mult_after_flush", MULDIV_OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1, 0);

      // Reset pulsed in the middle of a divide.
      @(posedge clk); #1;
      start_i = 1'b1; op_i = MULDIV_OP_DIVU; a_i = 32'd1000; b_i = 32'd3;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_mid_hi", hi_o, 32'h0);
      check("rst_mid_lo", lo_o, 32'h0);
      check("rst_mid_done", done_o, 1'b0);
      check("rst_mid_stall_eq", stall_o, 1'b1);
      start_i = 1'b0;
      #1;
      check("rst_mid_stall", stall_o, 1'b0);
      @(posedge clk); #2;
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      check("rst_no_done", 64'(dones), 64'd0);
      run_op("multu_after_rst", MULDIV_OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1, 0);
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage. It owns the HI/LO write path for these four instructions. It runs a one-cycle registered multiply or a 32-iteration radix-2 restoring divide, and stalls the pipeline until the result is ready. On completion it presents one-cycle `hilo_we_o` with HI/LO values to the hilo register file.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clk  in  1`: clock.
- `rst  in  1`: reset; asynchronous, active-high.
- `start_i  in  1`: EX holds a valid mult/div instruction. Held high by the stalled pipeline until `done_o`.
- `op_i  in  2`: operation: MULT, MULTU, DIV or DIVU, encoded per `muldiv_pkg`.
- `a_i  in  32`: rs operand (dividend / multiplicand).
- `b_i  in  32`: rt operand (divisor / multiplier).
- `flush_i  in  1`: exception/flush of EX; cancels any operation.
- `stall_o  out  1`: request to freeze IF..EX.
- `done_o  out  1`: result valid, single cycle.
- `hilo_we_o  out  1`: HI/LO write enable; equal to `done_o`.
- `hi_o  out  32`: product high word, or remainder.
- `lo_o  out  32`: product low word, or quotient.

## Operation
- States: `IDLE`, `DIV`, `DONE`.
- **IDLE**
  - `start_i && !flush_i` with MULT/MULTU: register the 64-bit product (signed or unsigned) into `{hi,lo}`, then go to `DONE`.
  - `start_i && !flush_i` with DIV/DIVU: latch operand magnitudes, the quotient sign (signed op and `a[31]^b[31]`) and the remainder sign (signed op and `a[31]`). Clear the 5-bit counter and partial remainder, then go to `DIV`.
- **DIV**
  - Each cycle: shift the partial remainder left by one, bringing in the next dividend bit (MSB first).
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1.
  - The counter increments each cycle. After iteration 31, apply the sign fixes (two's-complement negate the quotient and/or remainder) and go to `DONE`.
- **DONE**: `done_o = hilo_we_o = 1` for exactly one cycle, then go to `IDLE`. `hi_o`/`lo_o` hold their value until the next completion.
- Divide by zero (`b_i == 0`, signed or unsigned): still takes the full 32 iterations. Result is forced to `HI = a_i`, `LO = 0xFFFFFFFF`.
- Signed overflow (`0x80000000 / -1`): `LO = 0x80000000`, `HI = 0`. This is what the magnitude algorithm produces naturally.
- Operands are sampled only at the start cycle. Later changes on `a_i`/`b_i`/`op_i` are ignored.
- `stall_o = (state==IDLE && start_i && !flush_i) || state==DIV`. It is combinational and low in `DONE`, which lets the instruction advance in the same cycle that HI/LO is written.
- `flush_i` in any state: next state is `IDLE`. `done_o`/`hilo_we_o` are not asserted, and `hi_o`/`lo_o` are unchanged. Flush has priority over start and over `DIV`→`DONE`.
- `start_i` seen in `DONE` is not accepted. A new start is accepted only from `IDLE`.

## Timing
- Reset: state `IDLE`, counter 0, `hi_o = lo_o = 0`, `done_o = hilo_we_o = 0`. `stall_o` follows its equation, so it is 0 unless `start_i` is high.
- Accept cycle is T.
  - MULT/MULTU: `stall_o` high in T only; `done_o` high in T+1.
  - DIV/DIVU: `stall_o` high T..T+32; `done_o` high in T+33.
- Back-to-back operations: a new start can be accepted in T+2 (mult) or T+34 (div).
- Reset mid-operation: immediate return to reset values; no write.

## Structure
- `muldiv_pkg` holds:
  - `MULDIV_OP_MULT/MULTU/DIV/DIVU` encodings;
  - the state enum;
  - `WIDTH`;
  - `DIV_ITERS = 32`.
- Sub-module `div_radix2_step`: combinational single restoring step. Takes partial remainder, next dividend bit and divisor; returns new remainder and quotient bit. Instantiated once; the FSM and registers live in `muldiv_ctrl`.

## Test plan
- MULTU `a=0xFFFFFFFF`, `b=2` → `stall_o` high 1 cycle; T+1: `HI=0x00000001`, `LO=0xFFFFFFFE`, `hilo_we_o=1`.
- MULT `a=-3`, `b=5` → T+1: `HI=0xFFFFFFFF`, `LO=0xFFFFFFF1`.
- DIV `a=-7`, `b=2` → `stall_o` high 33 cycles; T+33: `LO=0xFFFFFFFD`, `HI=0xFFFFFFFF`. DIVU `100/7` → `LO=14`, `HI=2`.
- DIVU `5/0` and DIV `-5/0` → T+33: `HI=a_i`, `LO=0xFFFFFFFF`.
- DIV started, `flush_i` at T+10 → T+11 in `IDLE`, `stall_o=0`, no `hilo_we_o`, HI/LO unchanged. MULT accepted at T+11 completes at T+12.
- `rst` pulsed at T+5 of DIV → all outputs at reset values immediately; no `done_o` afterwards. Operand change on `a_i` during `DIV` does not affect the result.
